divider: RTL and testbench

//  Sequential signed 64/64 integer divider, the inverse of the Booth multiplier in the FactoCtr datapath.

---
 rtl/divider_pkg.sv | 18 +
 rtl/divider_if.sv | 33 +++
 rtl/divider_cla64.sv | 56 +++++
 rtl/divider.sv | 196 +++++++++++++++++++
 tb/tb_divider.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider.
// Contents:
//   DIV_WIDTH  operand width (64; the trial subtract and negations run on the 64-bit CLA)
//   DIV_CNT_W  iteration counter width (counts 0..DIV_WIDTH)
//   state_e    controller states IDLE/BUSY/FIX/DONE with fixed encodings
package divider_pkg;

   localparam int DIV_WIDTH = 64;
   localparam int DIV_CNT_W = 7;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/divider_if.sv
// Command/result bundle of the divider.
// Signals:
//   op_start   start pulse (sampled only while idle)
//   op_clear   synchronous clear back to idle
//   dividend   signed dividend, captured on the start edge
//   divisor    signed divisor, captured on the start edge
//   op_done    result valid, held until clear/reset
//   quotient   signed quotient (truncated toward zero)
//   remainder  signed remainder (takes the dividend's sign)
//   div_zero   divisor was zero; meaningful while op_done=1
// Modports: master = sequencer side, slave = divider side.
interface divider_if #(
   parameter int WIDTH = 64
);
   logic             op_start;
   logic             op_clear;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             op_done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output op_start, op_clear, dividend, divisor,
      input  op_done, quotient, remainder, div_zero
   );

   modport slave (
      input  op_start, op_clear, dividend, divisor,
      output op_done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/divider_cla64.sv
// 64-bit carry-lookahead adder: s_o = a_i + b_i + ci_i, co_o = carry out.
// Built from sixteen 4-bit lookahead groups; the group carries chain
// through the group generate/propagate terms.
// Ports:
//   a_i, b_i  64-bit addends
//   ci_i      carry in
//   s_o       64-bit sum
//   co_o      carry out of bit 63
module divider_cla64 (
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   input  logic        ci_i,
   output logic [63:0] s_o,
   output logic        co_o
);

   logic [63:0] g;
   logic [63:0] p;
   logic [63:0] c;
   logic [15:0] gg;
   logic [15:0] gp;
   logic [16:0] gc;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   for (genvar gi = 0; gi < 16; gi++) begin : g_grp
      assign gg[gi] = g[4*gi+3]
                    | (p[4*gi+3] & g[4*gi+2])
                    | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                    | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
      assign gp[gi] = &p[4*gi +: 4];

      // Bit carries inside a group are expanded directly from the group carry-in.
      assign c[4*gi]   = gc[gi];
      assign c[4*gi+1] = g[4*gi] | (p[4*gi] & gc[gi]);
      assign c[4*gi+2] = g[4*gi+1]
                       | (p[4*gi+1] & g[4*gi])
                       | (p[4*gi+1] & p[4*gi] & gc[gi]);
      assign c[4*gi+3] = g[4*gi+2]
                       | (p[4*gi+2] & g[4*gi+1])
                       | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                       | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & gc[gi]);
   end

   always_comb begin
      gc[0] = ci_i;
      for (int k = 0; k < 16; k++) begin
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
      end
   end

   assign s_o  = p ^ c;
   assign co_o = gc[16];

endmodule

// File: rtl/divider.sv
// Sequential signed divider, radix-2 restoring, one quotient bit per clock.
// Quotient truncates toward zero; remainder carries the dividend's sign.
// Ports:
//   clk      clock, all state on posedge
//   reset_n  synchronous active-low reset
//   bus      divider_if slave: op_start/op_clear/dividend/divisor in,
//            op_done/quotient/remainder/div_zero out
// Timing: start sampled at edge k -> op_done visible after edge k+65;
// divide by zero -> op_done visible after edge k+1.
//
// Two CLA instances are used: cla_a does the magnitude of the dividend
// (IDLE), the trial subtract (BUSY) and the quotient negation (FIX);
// cla_b does the magnitude of the divisor (IDLE) and the remainder
// negation (FIX). Having both negations in the same cycle keeps FIX to a
// single clock.
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic      clk,
   input  logic      reset_n,
   divider_if.slave  bus
);

   state_e           state_q, state_d;
   logic             sgn_quo_q, sgn_quo_d;
   logic             sgn_rem_q, sgn_rem_d;
   logic             zdiv_q, zdiv_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;

   logic [WIDTH-1:0] a_a, a_b, a_s;
   logic             a_ci, a_co;
   logic [WIDTH-1:0] b_a, b_b, b_s;
   logic             b_ci, unused_b_co;
   logic [WIDTH-1:0] rem_sh;

   // Remainder shifted left with the next dividend bit. The remainder stays
   // below the divisor magnitude (<= 2^63), so the dropped top bit is always 0.
   assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

   divider_cla64 u_cla_a (
      .a_i  (a_a),
      .b_i  (a_b),
      .ci_i (a_ci),
      .s_o  (a_s),
      .co_o (a_co)
   );

   divider_cla64 u_cla_b (
      .a_i  (b_a),
      .b_i  (b_b),
      .ci_i (b_ci),
      .s_o  (b_s),
      .co_o (unused_b_co)
   );

   // Adder operand steering; negation is 0 + ~x + 1.
   always_comb begin
      a_a  = '0;
      a_b  = '0;
      a_ci = 1'b0;
      b_a  = '0;
      b_b  = '0;
      b_ci = 1'b0;
      case (state_q)
         IDLE: begin
            a_b  = ~bus.dividend;
            a_ci = 1'b1;
            b_b  = ~bus.divisor;
            b_ci = 1'b1;
         end
         BUSY: begin
            // co=1 means rem_sh >= divisor magnitude
            a_a  = rem_sh;
            a_b  = ~dvs_q;
            a_ci = 1'b1;
         end
         FIX: begin
            a_b  = ~quo_q;
            a_ci = 1'b1;
            b_b  = ~rem_q;
            b_ci = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sgn_quo_d = sgn_quo_q;
      sgn_rem_d = sgn_rem_q;
      zdiv_d    = zdiv_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      done_d    = done_q;
      dz_d      = dz_q;
      quot_d    = quot_q;
      remo_d    = remo_q;
      case (state_q)
         IDLE: begin
            if (bus.op_start) begin
               state_d = FIX;
               cnt_d   = '0;
               if (bus.divisor == '0) begin
                  // Raw dividend parked in rem_q; FIX publishes it unchanged.
                  zdiv_d    = 1'b1;
                  sgn_quo_d = 1'b0;
                  sgn_rem_d = 1'b0;
                  quo_d     = '0;
                  rem_d     = bus.dividend;
                  dvs_d     = '0;
               end else begin
                  state_d   = BUSY;
                  zdiv_d    = 1'b0;
                  sgn_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  sgn_rem_d = bus.dividend[WIDTH-1];
                  // As unsigned 64-bit, -(-2^63) is 2^63, so no overflow here.
                  quo_d     = bus.dividend[WIDTH-1] ? a_s : bus.dividend;
                  dvs_d     = bus.divisor[WIDTH-1] ? b_s : bus.divisor;
                  rem_d     = '0;
               end
            end
         end
         BUSY: begin
            quo_d = {quo_q[WIDTH-2:0], a_co};
            rem_d = a_co ? a_s : rem_sh;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            state_d = DONE;
            done_d  = 1'b1;
            if (zdiv_q) begin
               dz_d   = 1'b1;
               quot_d = '1;
               remo_d = rem_q;
            end else begin
               dz_d   = 1'b0;
               quot_d = sgn_quo_q ? a_s : quo_q;
               remo_d = sgn_rem_q ? b_s : rem_q;
            end
         end
         DONE: ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n || bus.op_clear) begin
         state_q   <= IDLE;
         sgn_quo_q <= 1'b0;
         sgn_rem_q <= 1'b0;
         zdiv_q    <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         quot_q    <= '0;
         remo_q    <= '0;
      end else begin
         state_q   <= state_d;
         sgn_quo_q <= sgn_quo_d;
         sgn_rem_q <= sgn_rem_d;
         zdiv_q    <= zdiv_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         quot_q    <= quot_d;
         remo_q    <= remo_d;
      end
   end

   assign bus.op_done   = done_q;
   assign bus.quotient  = quot_q;
   assign bus.remainder = remo_q;
   assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the signed divider: latency, sign cases, divide by
// zero, overflow corner, abort by clear/reset, ignored restarts, and a
// short batch of random pairs checked against native signed division.
module tb_divider;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   divider_if #(.WIDTH(64)) bus ();

   divider dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [63:0] a, input logic [63:0] b);
      bus.op_start = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      tick();
      bus.op_start = 1'b0;
      bus.dividend = 64'hA5A5_5A5A_0F0F_F0F0;
      bus.divisor  = 64'h0000_0000_0000_0003;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!bus.op_done && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic clear_chk(input string tag);
      bus.op_clear = 1'b1;
      tick();
      bus.op_clear = 1'b0;
      chk({tag, " clr done"}, 64'(bus.op_done), 64'd0);
      chk({tag, " clr quo"}, bus.quotient, 64'd0);
   endtask

   task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] eq, input logic [63:0] er, input logic edz,
                      input int elat, output logic [63:0] oq, output logic [63:0] orr);
      int n;
      start_op(a, b);
      wait_done(n);
      chk({tag, " lat"}, 64'(n), 64'(elat));
      chk({tag, " quo"}, bus.quotient, eq);
      chk({tag, " rem"}, bus.remainder, er);
      chk({tag, " dz"}, 64'(bus.div_zero), 64'(edz));
      oq  = bus.quotient;
      orr = bus.remainder;
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, " done"}, 64'(bus.op_done), 64'd0);
      chk({tag, " quo"}, bus.quotient, 64'd0);
      chk({tag, " rem"}, bus.remainder, 64'd0);
      chk({tag, " dz"}, 64'(bus.div_zero), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] q, r;
      int          n;
      longint      sa, sb, sq, sr;

      bus.op_start = 1'b0;
      bus.op_clear = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      reset_n      = 1'b0;
      tick();
      tick();
      zero_chk("reset");
      reset_n = 1'b1;
      tick();

      run("100/7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, q, r);
      clear_chk("100/7");
      run("-100/7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
          64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65, q, r);
      clear_chk("-100/7");
      run("100/-7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
          64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 65, q, r);
      clear_chk("100/-7");
      run("-100/-7", 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
          64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65, q, r);
      clear_chk("-100/-7");
      run("5/0", 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1'b1, 1, q, r);
      clear_chk("5/0");
      chk("5/0 clr dz", 64'(bus.div_zero), 64'd0);
      run("min/-1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 64'd0, 1'b0, 65, q, r);
      clear_chk("min/-1");
      run("min/1", 64'h8000_0000_0000_0000, 64'd1,
          64'h8000_0000_0000_0000, 64'd0, 1'b0, 65, q, r);
      clear_chk("min/1");

      // Abort by clear at iteration 30
      start_op(64'd1000, 64'd3);
      repeat (29) tick();
      chk("mid busy done", 64'(bus.op_done), 64'd0);
      chk("mid busy quo", bus.quotient, 64'd0);
      bus.op_clear = 1'b1;
      tick();
      bus.op_clear = 1'b0;
      zero_chk("abort clr");
      run("9/3 after clr", 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 65, q, r);
      clear_chk("9/3 after clr");

      // Abort by reset mid-busy
      start_op(64'd1000, 64'd3);
      repeat (20) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      zero_chk("abort rst");
      run("100/7 after rst", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, q, r);

      // Start while in DONE is ignored
      bus.op_start = 1'b1;
      bus.dividend = 64'd50;
      bus.divisor  = 64'd5;
      tick();
      bus.op_start = 1'b0;
      tick();
      chk("done restart quo", bus.quotient, 64'd14);
      chk("done restart rem", bus.remainder, 64'd2);
      clear_chk("done restart");

      // Start re-pulsed during BUSY is ignored
      start_op(64'd100, 64'd7);
      repeat (10) tick();
      bus.op_start = 1'b1;
      bus.dividend = 64'd50;
      bus.divisor  = 64'd5;
      tick();
      bus.op_start = 1'b0;
      wait_done(n);
      chk("repulse lat", 64'(n + 11), 64'd65);
      chk("repulse quo", bus.quotient, 64'd14);
      chk("repulse rem", bus.remainder, 64'd2);
      clear_chk("repulse");

      // Random signed pairs
      for (int i = 0; i < 40; i++) begin
         sa = longint'({$urandom(), $urandom()});
         if (i % 3 == 0) begin
            sb = longint'({$urandom(), $urandom()});
         end else if (i % 3 == 1) begin
            sb = longint'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) sb = -sb;
         end else begin
            sb = longint'($signed($urandom()));
         end
         if (sb == 0) sb = 7;
         sq = sa / sb;
         sr = sa % sb;
         run("rnd", sa, sb, sq, sr, 1'b0, 65, q, r);
         chk("rnd ident", q * sb + r, sa);
         sr = (longint'(r) < 0) ? -longint'(r) : longint'(r);
         sq = (sb < 0) ? -sb : sb;
         chk("rnd rem mag", 64'(sr < sq), 64'd1);
         clear_chk("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
